// File: rtl/lsu_fu_pipe.sv
// Load/store functional unit: EA generation, single request slot,
// in-order tracking FIFO, load alignment/extension, ROB completion.
module lsu_fu_pipe #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 4,
  parameter int ROB_W  = 5,
  parameter int PREG_W = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic [ROB_W-1:0]         issue_rob,
  input  logic [PREG_W-1:0]        issue_rd,
  input  logic [XLEN-1:0]          issue_base,
  input  logic [XLEN-1:0]          issue_imm,
  input  logic [XLEN-1:0]          issue_wdata,
  input  logic                     issue_store,
  input  logic [1:0]               issue_size,
  input  logic                     issue_unsigned,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic [XLEN-1:0]          req_addr,
  output logic                     req_we,
  output logic [XLEN/8-1:0]        req_be,
  output logic [XLEN-1:0]          req_wdata,
  input  logic                     resp_valid,
  input  logic [XLEN-1:0]          resp_rdata,
  output logic                     cmp_valid,
  input  logic                     cmp_ready,
  output logic [ROB_W-1:0]         cmp_rob,
  output logic [PREG_W-1:0]        cmp_rd,
  output logic [XLEN-1:0]          cmp_result,
  output logic                     cmp_store,
  output logic                     cmp_misaligned,
  output logic [$clog2(DEPTH):0]   inflight
);

  localparam int BW   = XLEN / 8;
  localparam int OFFW = $clog2(BW);
  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  function automatic logic [BW-1:0] size_mask(input logic [1:0] sz);
    int nb;
    nb = 1 << sz;
    if (nb >= BW) return '1;
    return BW'((1 << nb) - 1);
  endfunction

  function automatic logic [XLEN-1:0] ld_ext(
    input logic [XLEN-1:0] d,
    input logic [OFFW-1:0] off,
    input logic [1:0]      sz,
    input logic            uns
  );
    int              nb;
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] keep;
    logic            sb;
    sh = d >> {off, 3'b000};
    nb = 8 << sz;
    case (sz)
      2'd0:    sb = sh[7];
      2'd1:    sb = sh[15];
      default: sb = sh[31];
    endcase
    keep = (nb >= XLEN) ? '1 : ((XLEN'(1) << nb) - XLEN'(1));
    return (sh & keep) | (~keep & {XLEN{sb & ~uns}});
  endfunction

  logic [PTRW-1:0]   head_q, tail_q;
  logic [CNTW-1:0]   count_q, count_d;
  logic [ROB_W-1:0]  rob_q  [DEPTH];
  logic [PREG_W-1:0] rd_q   [DEPTH];
  logic [1:0]        size_q [DEPTH];
  logic [OFFW-1:0]   off_q  [DEPTH];
  logic [XLEN-1:0]   data_q [DEPTH];
  logic [DEPTH-1:0]  uns_q, st_q, mis_q, kill_q, done_q, sent_q;
  logic              rdy_q;

  logic              req_valid_q, req_we_q;
  logic [XLEN-1:0]   req_addr_q, req_wdata_q;
  logic [BW-1:0]     req_be_q;
  logic [PTRW-1:0]   req_idx_q;

  logic              cmp_valid_q, cmp_store_q, cmp_mis_q;
  logic [ROB_W-1:0]  cmp_rob_q;
  logic [PREG_W-1:0] cmp_rd_q;
  logic [XLEN-1:0]   cmp_result_q;

  logic [XLEN-1:0]   ea;
  logic [OFFW-1:0]   off;
  logic              mis;
  logic              take, cmp_free, direct, alloc;
  logic              head_vld, head_resp, head_done;
  logic [XLEN-1:0]   head_data, resp_data;
  logic              pop_kill, pop_cmp, pop, req_fire;
  logic              resp_hit;
  logic [PTRW-1:0]   resp_idx;

  assign ea  = issue_base + issue_imm;
  assign off = ea[OFFW-1:0];

  always_comb begin
    mis = 1'b0;
    case (issue_size)
      2'd1:    mis = ea[0];
      2'd2:    mis = |ea[1:0];
      2'd3:    mis = (XLEN == 32) || (|ea[2:0]);
      default: mis = 1'b0;
    endcase
  end

  // Responses arrive in send order, so the oldest sent-but-pending entry owns it.
  always_comb begin
    logic [PTRW-1:0] idx;
    resp_hit = 1'b0;
    resp_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTRW'(i);
      if (!resp_hit && (CNTW'(i) < count_q) &&
          !done_q[idx] && sent_q[idx]) begin
        resp_hit = 1'b1;
        resp_idx = idx;
      end
    end
  end

  assign resp_data = st_q[resp_idx] ? '0 :
    ld_ext(resp_rdata, off_q[resp_idx], size_q[resp_idx], uns_q[resp_idx]);

  assign issue_ready = rdy_q && (count_q < CNTW'(DEPTH)) &&
                       (!req_valid_q || req_ready);

  assign take     = issue_valid && issue_ready && !flush;
  assign cmp_free = !cmp_valid_q || cmp_ready;
  // A misaligned op into an empty unit goes straight to the completion slot.
  assign direct   = take && mis && (count_q == '0) && cmp_free;
  assign alloc    = take && !direct;
  assign req_fire = req_valid_q && req_ready;

  assign head_vld  = count_q != '0;
  assign head_resp = resp_valid && resp_hit && (resp_idx == head_q);
  assign head_done = done_q[head_q] || head_resp;
  assign head_data = head_resp ? resp_data : data_q[head_q];

  assign pop_kill = head_vld && head_done && kill_q[head_q];
  assign pop_cmp  = head_vld && head_done && !kill_q[head_q] &&
                    !flush && cmp_free;
  assign pop      = pop_kill || pop_cmp;
  assign count_d  = count_q + CNTW'(alloc) - CNTW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rdy_q   <= 1'b0;
      uns_q   <= '0;
      st_q    <= '0;
      mis_q   <= '0;
      kill_q  <= '0;
      done_q  <= '0;
      sent_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rob_q[i]  <= '0;
        rd_q[i]   <= '0;
        size_q[i] <= '0;
        off_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      rdy_q   <= 1'b1;
      count_q <= count_d;
      if (pop) head_q <= head_q + 1'b1;
      if (alloc) begin
        tail_q         <= tail_q + 1'b1;
        rob_q[tail_q]  <= issue_rob;
        rd_q[tail_q]   <= issue_rd;
        size_q[tail_q] <= issue_size;
        off_q[tail_q]  <= off;
        data_q[tail_q] <= '0;
        uns_q[tail_q]  <= issue_unsigned;
        st_q[tail_q]   <= issue_store;
        mis_q[tail_q]  <= mis;
        kill_q[tail_q] <= 1'b0;
        done_q[tail_q] <= mis;
        sent_q[tail_q] <= 1'b0;
      end
      if (req_fire) sent_q[req_idx_q] <= 1'b1;
      if (resp_valid && resp_hit) begin
        done_q[resp_idx] <= 1'b1;
        data_q[resp_idx] <= resp_data;
      end
      if (flush) begin
        kill_q <= '1;
        if (req_valid_q && !req_ready) done_q[req_idx_q] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_be_q    <= '0;
      req_idx_q   <= '0;
    end else if (alloc && !mis) begin
      req_valid_q <= 1'b1;
      req_we_q    <= issue_store;
      req_addr_q  <= {ea[XLEN-1:OFFW], {OFFW{1'b0}}};
      req_wdata_q <= issue_wdata << {off, 3'b000};
      req_be_q    <= size_mask(issue_size) << off;
      req_idx_q   <= tail_q;
    end else if (flush || req_fire) begin
      req_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_valid_q  <= 1'b0;
      cmp_store_q  <= 1'b0;
      cmp_mis_q    <= 1'b0;
      cmp_rob_q    <= '0;
      cmp_rd_q     <= '0;
      cmp_result_q <= '0;
    end else if (flush) begin
      cmp_valid_q <= 1'b0;
    end else if (direct) begin
      cmp_valid_q  <= 1'b1;
      cmp_store_q  <= issue_store;
      cmp_mis_q    <= 1'b1;
      cmp_rob_q    <= issue_rob;
      cmp_rd_q     <= issue_rd;
      cmp_result_q <= '0;
    end else if (pop_cmp) begin
      cmp_valid_q  <= 1'b1;
      cmp_store_q  <= st_q[head_q];
      cmp_mis_q    <= mis_q[head_q];
      cmp_rob_q    <= rob_q[head_q];
      cmp_rd_q     <= rd_q[head_q];
      cmp_result_q <= head_data;
    end else if (cmp_ready) begin
      cmp_valid_q <= 1'b0;
    end
  end

  assign req_valid      = req_valid_q;
  assign req_addr       = req_addr_q;
  assign req_we         = req_we_q;
  assign req_be         = req_be_q;
  assign req_wdata      = req_wdata_q;
  assign cmp_valid      = cmp_valid_q;
  assign cmp_rob        = cmp_rob_q;
  assign cmp_rd         = cmp_rd_q;
  assign cmp_result     = cmp_result_q;
  assign cmp_store      = cmp_store_q;
  assign cmp_misaligned = cmp_mis_q;
  assign inflight       = count_q;

endmodule

// File: tb/tb_lsu_fu_pipe.sv
// Scoreboard bench for lsu_fu_pipe: request and completion queues
// filled at issue time and drained by negedge monitors.
module tb_lsu_fu_pipe;

  localparam int XLEN   = 32;
  localparam int DEPTH  = 4;
  localparam int ROB_W  = 5;
  localparam int PREG_W = 6;

  logic              clk, rst_n, flush;
  logic              issue_valid, issue_ready;
  logic [ROB_W-1:0]  issue_rob;
  logic [PREG_W-1:0] issue_rd;
  logic [31:0]       issue_base, issue_imm, issue_wdata;
  logic              issue_store, issue_unsigned;
  logic [1:0]        issue_size;
  logic              req_valid, req_ready, req_we;
  logic [31:0]       req_addr, req_wdata;
  logic [3:0]        req_be;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              cmp_valid, cmp_ready, cmp_store, cmp_misaligned;
  logic [ROB_W-1:0]  cmp_rob;
  logic [PREG_W-1:0] cmp_rd;
  logic [31:0]       cmp_result;
  logic [2:0]        inflight;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } req_t;

  typedef struct {
    logic [4:0]  rob;
    logic [5:0]  rd;
    logic [31:0] res;
    logic        st;
    logic        mis;
  } cmp_t;

  req_t        rq[$];
  logic [31:0] rsq[$];
  cmp_t        cq[$];
  int          n_vec, n_err;
  bit          resp_hold, rand_resp, rand_cmp, cmp_rdy_set;
  logic        cmp_rnd;

  lsu_fu_pipe #(.XLEN(XLEN), .DEPTH(DEPTH), .ROB_W(ROB_W), .PREG_W(PREG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rob(issue_rob), .issue_rd(issue_rd),
    .issue_base(issue_base), .issue_imm(issue_imm),
    .issue_wdata(issue_wdata), .issue_store(issue_store),
    .issue_size(issue_size), .issue_unsigned(issue_unsigned),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_be(req_be), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .cmp_valid(cmp_valid), .cmp_ready(cmp_ready), .cmp_rob(cmp_rob),
    .cmp_rd(cmp_rd), .cmp_result(cmp_result), .cmp_store(cmp_store),
    .cmp_misaligned(cmp_misaligned), .inflight(inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign cmp_ready = rand_cmp ? cmp_rnd : cmp_rdy_set;

  always @(posedge clk) begin
    #1;
    cmp_rnd = 1'($urandom_range(0, 1));
    if (!rst_n) begin
      resp_valid = 1'b0;
    end else if (!resp_hold && rsq.size() > 0 &&
                 (!rand_resp || $urandom_range(0, 2) != 0)) begin
      resp_valid = 1'b1;
      resp_rdata = rsq.pop_front();
    end else begin
      resp_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    req_t er;
    cmp_t ec;
    if (rst_n) begin
      if (req_valid && req_ready) begin
        n_vec++;
        if (rq.size() == 0) begin
          n_err++;
          $display("FAIL req_unexpected addr=%h be=%h (none required)", req_addr, req_be);
        end else begin
          er = rq.pop_front();
          if ({req_addr, req_we, req_be, req_wdata} !==
              {er.addr, er.we, er.be, er.wdata}) begin
            n_err++;
            $display("FAIL req_fields got addr=%h we=%b be=%h wd=%h want addr=%h we=%b be=%h wd=%h",
                     req_addr, req_we, req_be, req_wdata, er.addr, er.we, er.be, er.wdata);
          end
          rsq.push_back(er.rdata);
        end
      end
      if (cmp_valid && cmp_ready) begin
        n_vec++;
        if (cq.size() == 0) begin
          n_err++;
          $display("FAIL cmp_unexpected rob=%0d res=%h (none required)", cmp_rob, cmp_result);
        end else begin
          ec = cq.pop_front();
          if ({cmp_rob, cmp_rd, cmp_result, cmp_store, cmp_misaligned} !==
              {ec.rob, ec.rd, ec.res, ec.st, ec.mis}) begin
            n_err++;
            $display("FAIL cmp_fields got rob=%0d rd=%0d res=%h st=%b mis=%b want rob=%0d rd=%0d res=%h st=%b mis=%b",
                     cmp_rob, cmp_rd, cmp_result, cmp_store, cmp_misaligned,
                     ec.rob, ec.rd, ec.res, ec.st, ec.mis);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_req(input logic [31:0] a, input logic we, input logic [3:0] be,
                          input logic [31:0] wd, input logic [31:0] rd_data);
    rq.push_back('{addr: a, we: we, be: be, wdata: wd, rdata: rd_data});
  endtask

  task automatic push_cmp(input logic [4:0] rob, input logic [5:0] rd,
                          input logic [31:0] res, input logic st, input logic mis);
    cq.push_back('{rob: rob, rd: rd, res: res, st: st, mis: mis});
  endtask

  task automatic do_issue(input logic [4:0] rob, input logic [5:0] rd,
                          input logic [31:0] base, input logic [31:0] imm,
                          input logic [31:0] wd, input logic st,
                          input logic [1:0] sz, input logic uns);
    bit ok;
    int n;
    issue_valid = 1'b1;
    issue_rob = rob; issue_rd = rd; issue_base = base; issue_imm = imm;
    issue_wdata = wd; issue_store = st; issue_size = sz; issue_unsigned = uns;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 60) begin
      @(negedge clk);
      ok = issue_ready;
      tick();
      n++;
    end
    issue_valid = 1'b0;
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL issue_timeout rob=%0d got no accept want accept within 60 cycles", rob);
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (rq.size() == 0 && rsq.size() == 0 && cq.size() == 0 &&
          inflight == 0 && !cmp_valid && !req_valid && !resp_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [31:0] d, input int off,
                                           input int sz, input bit uns);
    logic [31:0] s;
    s = d >> (8 * off);
    case (sz)
      0:       return uns ? {24'h0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
      1:       return uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: return s;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    n_vec++;
    if ({req_valid, cmp_valid, issue_ready, inflight} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs got rv=%b cv=%b ir=%b inf=%0d want all 0",
               req_valid, cmp_valid, issue_ready, inflight);
    end
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (issue_ready !== 1'b1 || inflight !== 3'd0 || req_valid !== 1'b0 || cmp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release got ir=%b inf=%0d rv=%b cv=%b want ir=1 inf=0 rv=0 cv=0",
               issue_ready, inflight, req_valid, cmp_valid);
    end
  endtask

  task automatic test_load_w(input logic [4:0] rob);
    bit ok;
    push_req(32'h104, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF);
    push_cmp(rob, 6'd2, 32'hDEADBEEF, 1'b0, 1'b0);
    do_issue(rob, 6'd2, 32'h100, 32'd4, 32'h0, 1'b0, 2'd2, 1'b0);
    n_vec++;
    if (req_valid !== 1'b1 || req_addr !== 32'h104 || req_be !== 4'hF) begin
      n_err++;
      $display("FAIL loadw_req got rv=%b addr=%h be=%h want rv=1 addr=00000104 be=f",
               req_valid, req_addr, req_be);
    end
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      tick();
      ok = resp_valid;
    end
    tick();
    n_vec++;
    if (cmp_valid !== 1'b1 || cmp_result !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL loadw_cmp_latency got cv=%b res=%h want cv=1 res=deadbeef", cmp_valid, cmp_result);
    end
    wait_idle(50, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL loadw_drain got busy inf=%0d want idle", inflight);
    end
  endtask

  task automatic test_load_b();
    bit ok;
    push_req(32'h200, 1'b0, 4'h8, 32'h0, 32'h80FFFFFF);
    push_cmp(5'd3, 6'd4, 32'hFFFFFF80, 1'b0, 1'b0);
    push_req(32'h200, 1'b0, 4'h8, 32'h0, 32'h80FFFFFF);
    push_cmp(5'd4, 6'd5, 32'h00000080, 1'b0, 1'b0);
    do_issue(5'd3, 6'd4, 32'h200, 32'd3, 32'h0, 1'b0, 2'd0, 1'b0);
    do_issue(5'd4, 6'd5, 32'h1FF, 32'd4, 32'h0, 1'b0, 2'd0, 1'b1);
    wait_idle(50, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL loadb_drain got busy inf=%0d want idle", inflight);
    end
  endtask

  task automatic test_store_h();
    bit ok;
    push_req(32'h300, 1'b1, 4'hC, 32'h12340000, 32'h0);
    push_cmp(5'd5, 6'd7, 32'h0, 1'b1, 1'b0);
    do_issue(5'd5, 6'd7, 32'h300, 32'd2, 32'h1234, 1'b1, 2'd1, 1'b0);
    n_vec++;
    if (req_we !== 1'b1 || req_be !== 4'hC || req_wdata !== 32'h12340000) begin
      n_err++;
      $display("FAIL storeh_req got we=%b be=%h wd=%h want we=1 be=c wd=12340000",
               req_we, req_be, req_wdata);
    end
    wait_idle(50, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL storeh_drain got busy inf=%0d want idle", inflight);
    end
  endtask

  task automatic test_misaligned();
    bit ok;
    push_cmp(5'd6, 6'd8, 32'h0, 1'b0, 1'b1);
    do_issue(5'd6, 6'd8, 32'h100, 32'd1, 32'h0, 1'b0, 2'd2, 1'b0);
    n_vec++;
    if (cmp_valid !== 1'b1 || cmp_misaligned !== 1'b1 || req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL misw_latency got cv=%b mis=%b rv=%b want cv=1 mis=1 rv=0",
               cmp_valid, cmp_misaligned, req_valid);
    end
    push_cmp(5'd7, 6'd9, 32'h0, 1'b0, 1'b1);
    push_cmp(5'd8, 6'd10, 32'h0, 1'b0, 1'b1);
    push_cmp(5'd9, 6'd11, 32'h0, 1'b1, 1'b1);
    do_issue(5'd7, 6'd9, 32'h200, 32'd1, 32'h0, 1'b0, 2'd1, 1'b0);
    do_issue(5'd8, 6'd10, 32'h100, 32'd0, 32'h0, 1'b0, 2'd3, 1'b0);
    do_issue(5'd9, 6'd11, 32'h102, 32'd0, 32'h55, 1'b1, 2'd2, 1'b0);
    wait_idle(50, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL mis_drain got busy inf=%0d want idle", inflight);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    req_ready = 1'b0;
    push_req(32'h400, 1'b0, 4'hF, 32'h0, 32'h11112222);
    push_cmp(5'd9, 6'd1, 32'h11112222, 1'b0, 1'b0);
    do_issue(5'd9, 6'd1, 32'h400, 32'd0, 32'h0, 1'b0, 2'd2, 1'b0);
    n_vec++;
    if (issue_ready !== 1'b0 || req_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_req_stall got ir=%b rv=%b want ir=0 rv=1", issue_ready, req_valid);
    end
    req_ready = 1'b1;
    wait_idle(50, ok);
    resp_hold = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      push_req(32'h500 + 32'(4 * i), 1'b0, 4'hF, 32'h0, 32'hA0000000 + 32'(i));
      push_cmp(5'(10 + i), 6'(20 + i), 32'hA0000000 + 32'(i), 1'b0, 1'b0);
      do_issue(5'(10 + i), 6'(20 + i), 32'h500, 32'(4 * i), 32'h0, 1'b0, 2'd2, 1'b0);
    end
    n_vec++;
    if (inflight !== 3'(DEPTH) || issue_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_full got inf=%0d ir=%b want inf=%0d ir=0", inflight, issue_ready, DEPTH);
    end
    cmp_rdy_set = 1'b0;
    resp_hold = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      tick();
      ok = cmp_valid;
    end
    repeat (3) tick();
    n_vec++;
    if (cmp_valid !== 1'b1 || cmp_rob !== 5'd10 || cmp_rd !== 6'd20 ||
        cmp_result !== 32'hA0000000) begin
      n_err++;
      $display("FAIL bp_cmp_hold got cv=%b rob=%0d rd=%0d res=%h want cv=1 rob=10 rd=20 res=a0000000",
               cmp_valid, cmp_rob, cmp_rd, cmp_result);
    end
    cmp_rdy_set = 1'b1;
    wait_idle(80, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL bp_drain got busy inf=%0d want idle", inflight);
    end
  endtask

  task automatic test_flush();
    bit ok;
    resp_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_req(32'h600 + 32'(4 * i), 1'b0, 4'hF, 32'h0, 32'h77770000 + 32'(i));
      do_issue(5'(16 + i), 6'(30 + i), 32'h600, 32'(4 * i), 32'h0, 1'b0, 2'd2, 1'b0);
    end
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      ok = (rq.size() == 0) && !req_valid;
      if (!ok) tick();
    end
    n_vec++;
    if (inflight !== 3'd3 || !ok) begin
      n_err++;
      $display("FAIL flush_presend got inf=%0d sent=%b want inf=3 sent=1", inflight, ok);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    resp_hold = 1'b0;
    wait_idle(50, ok);
    n_vec++;
    if (!ok || inflight !== 3'd0) begin
      n_err++;
      $display("FAIL flush_absorb got inf=%0d pend=%0d want inf=0 pend=0", inflight, rsq.size());
    end
    test_load_w(5'd20);

    req_ready = 1'b0;
    do_issue(5'd21, 6'd1, 32'h700, 32'd0, 32'h0, 1'b0, 2'd2, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_vec++;
    if (req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_drop_req got rv=%b want rv=0", req_valid);
    end
    tick();
    n_vec++;
    if (inflight !== 3'd0) begin
      n_err++;
      $display("FAIL flush_drop_pop got inf=%0d want 0", inflight);
    end
    req_ready = 1'b1;

    cmp_rdy_set = 1'b0;
    push_req(32'h800, 1'b0, 4'hF, 32'h0, 32'h12345678);
    do_issue(5'd22, 6'd2, 32'h800, 32'd0, 32'h0, 1'b0, 2'd2, 1'b0);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      tick();
      ok = cmp_valid;
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_vec++;
    if (cmp_valid !== 1'b0 || inflight !== 3'd0) begin
      n_err++;
      $display("FAIL flush_cmp_clear got cv=%b inf=%0d want cv=0 inf=0", cmp_valid, inflight);
    end
    cmp_rdy_set = 1'b1;

    issue_valid = 1'b1;
    issue_base = 32'h900; issue_imm = 32'h0; issue_size = 2'd2;
    issue_store = 1'b0; issue_unsigned = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    issue_valid = 1'b0;
    n_vec++;
    if (inflight !== 3'd0 || req_valid !== 1'b0 || cmp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_issue_drop got inf=%0d rv=%b cv=%b want 0 0 0",
               inflight, req_valid, cmp_valid);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    rand_resp = 1'b1;
    rand_cmp = 1'b1;
    for (int k = 0; k < 40; k++) begin
      int sz, off;
      bit st, uns, mis;
      logic [31:0] ea, imm, wd, rdat;
      logic [3:0] be;
      sz  = $urandom_range(0, 2);
      st  = ($urandom_range(0, 2) == 0);
      uns = 1'($urandom_range(0, 1));
      mis = ($urandom_range(0, 7) == 0);
      if (mis) begin
        sz = 2;
        off = $urandom_range(1, 3);
      end else begin
        off = (sz == 0) ? $urandom_range(0, 3) : (sz == 1) ? 2 * $urandom_range(0, 1) : 0;
      end
      ea   = 32'h1000 + {$urandom_range(0, 63), 2'b00} + 32'(off);
      imm  = 32'($urandom_range(0, 64)) - 32'd32;
      wd   = $urandom;
      rdat = $urandom;
      be   = (sz == 0) ? 4'h1 << off : (sz == 1) ? 4'h3 << off : 4'hF;
      if (mis) begin
        push_cmp(5'(k), 6'(k), 32'h0, st, 1'b1);
      end else begin
        push_req({ea[31:2], 2'b00}, st, be, wd << (8 * off), rdat);
        push_cmp(5'(k), 6'(k), st ? 32'h0 : exp_load(rdat, off, sz, uns), st, 1'b0);
      end
      do_issue(5'(k), 6'(k), ea - imm, imm, wd, st, 2'(sz), uns);
    end
    rand_resp = 1'b0;
    rand_cmp = 1'b0;
    wait_idle(300, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL b2b_drain got rq=%0d rsq=%0d cq=%0d inf=%0d want all 0",
               rq.size(), rsq.size(), cq.size(), inflight);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; flush = 1'b0;
    issue_valid = 1'b0; issue_rob = '0; issue_rd = '0;
    issue_base = '0; issue_imm = '0; issue_wdata = '0;
    issue_store = 1'b0; issue_size = 2'd0; issue_unsigned = 1'b0;
    req_ready = 1'b1; resp_valid = 1'b0; resp_rdata = '0;
    resp_hold = 1'b0; rand_resp = 1'b0; rand_cmp = 1'b0; cmp_rdy_set = 1'b1;
    test_reset();
    test_load_w(5'd1);
    test_load_b();
    test_store_h();
    test_misaligned();
    test_backpressure();
    test_flush();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
